// File: rtl/fphub_mult_arbiter_pkg.sv
// Shared types and constants for the two-requester HUB multiplier arbiter.
package fphub_mult_arbiter_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // HUB exponent bias is 2^(E-1), one more than the IEEE bias.
  function automatic int unsigned hub_bias(input int unsigned e);
    return 32'd1 << (e - 1);
  endfunction

endpackage

// File: rtl/FPHUB_mult.sv
// Combinational HUB floating-point multiplier; result is forced to zero
// unless start is high.
module FPHUB_mult
  import fphub_mult_arbiter_pkg::*;
#(
  parameter int M            = 23,
  parameter int E            = 8,
  parameter int special_case = 7
) (
  input  logic         start,
  input  logic [E+M:0] x,
  input  logic [E+M:0] y,
  output logic [E+M:0] z
);

  localparam logic [E+1:0] BIAS    = (E+2)'(hub_bias(E));
  localparam logic [E-1:0] ONE_EXP = E'(hub_bias(E) - 1);

  logic           sz;
  logic [E-1:0]   ex, ey;
  logic [M-1:0]   mx, my, mz;
  logic [M+1:0]   sig_x, sig_y;
  logic [2*M+3:0] prod;
  logic           ovf, prod_unused;
  logic [E+1:0]   ez;
  logic           zero_x, zero_y, inf_x, inf_y, one_x, one_y, e_under, e_over;
  logic [E+M:0]   res;

  assign sz = x[E+M] ^ y[E+M];
  assign ex = x[E+M-1:M];
  assign ey = y[E+M-1:M];
  assign mx = x[M-1:0];
  assign my = y[M-1:0];

  // Significands carry both the implicit leading 1 and the HUB implicit LSB.
  assign sig_x = {1'b1, mx, 1'b1};
  assign sig_y = {1'b1, my, 1'b1};
  assign prod  = sig_x * sig_y;
  assign ovf   = prod[2*M+3];
  // Truncation of a HUB value is round-to-nearest, so the low bits just drop.
  assign mz          = ovf ? prod[2*M+2:M+3] : prod[2*M+1:M+2];
  assign prod_unused = ^prod[M+1:0];

  assign ez      = {2'b00, ex} + {2'b00, ey} - BIAS + {{(E+1){1'b0}}, ovf};
  assign e_under = ez[E+1] || (ez == '0);
  assign e_over  = !ez[E+1] && (ez[E:0] >= {1'b0, {E{1'b1}}});

  // special_case bits: [0] zero operands, [1] infinite operands, [2] exact one.
  assign zero_x = special_case[0] && (ex == '0);
  assign zero_y = special_case[0] && (ey == '0);
  assign inf_x  = special_case[1] && (ex == '1);
  assign inf_y  = special_case[1] && (ey == '1);
  // The HUB code nearest 1.0 is treated as an exact one.
  assign one_x  = special_case[2] && (ex == ONE_EXP) && (mx == '1);
  assign one_y  = special_case[2] && (ey == ONE_EXP) && (my == '1);

  always_comb begin
    res = {sz, ez[E-1:0], mz};
    if (inf_x || inf_y)           res = {sz, {E{1'b1}}, {M{1'b0}}};
    else if (zero_x || zero_y)    res = {sz, {(E+M){1'b0}}};
    else if (one_x)               res = {sz, ey, my};
    else if (one_y)               res = {sz, ex, mx};
    else if (e_under)             res = {sz, {(E+M){1'b0}}};
    else if (e_over)              res = {sz, {E{1'b1}}, {M{1'b0}}};
  end

  assign z = start ? res : '0;

endmodule

// File: rtl/fphub_mult_arbiter.sv
// Round-robin arbiter sharing one HUB multiplier between two requesters,
// one operation in flight, result held until the consumer accepts it.
module fphub_mult_arbiter
  import fphub_mult_arbiter_pkg::*;
#(
  parameter int M            = 23,
  parameter int E            = 8,
  parameter int special_case = 7,
  parameter int LAT          = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [E+M:0] req_x0,
  input  logic [E+M:0] req_y0,
  input  logic [E+M:0] req_x1,
  input  logic [E+M:0] req_y1,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic         resp_id,
  output logic [E+M:0] resp_z,
  output logic         busy
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          last_grant;
  logic [E+M:0]  op_x, op_y, mult_z;
  logic          gnt_idx, mult_start;
  logic [1:0]    grant;

  // Tie goes to whoever was not served last; a lone request always wins.
  always_comb begin
    gnt_idx = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
    grant   = 2'b00;
    if (!rst && state == IDLE && req_valid != 2'b00)
      grant = gnt_idx ? 2'b10 : 2'b01;
  end

  assign req_ready  = grant;
  assign mult_start = (state == BUSY);
  assign resp_valid = (state == DONE);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= 1'b1;
      resp_id    <= 1'b0;
      resp_z     <= '0;
      op_x       <= '0;
      op_y       <= '0;
    end else begin
      case (state)
        IDLE: if (grant != 2'b00) begin
          op_x       <= gnt_idx ? req_x1 : req_x0;
          op_y       <= gnt_idx ? req_y1 : req_y0;
          resp_id    <= gnt_idx;
          last_grant <= gnt_idx;
          cnt        <= CW'(LAT - 1);
          state      <= BUSY;
        end
        BUSY: if (cnt == '0) begin
          resp_z <= mult_z;
          state  <= DONE;
        end else begin
          cnt <= cnt - 1'b1;
        end
        DONE: if (resp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  FPHUB_mult #(
    .M(M), .E(E), .special_case(special_case)
  ) u_mult (
    .start(mult_start),
    .x    (op_x),
    .y    (op_y),
    .z    (mult_z)
  );

endmodule

// File: doc/fphub_mult_arbiter.md
FPHUB_MULT_ARBITER -- requirements
Module: fphub_mult_arbiter

Interface
REQ-001 SHALL have parameter M, default 23, mantissa width excluding implicit bit.
REQ-002 SHALL have parameter E, default 8, exponent width.
REQ-003 SHALL have parameter special_case, default 7, number of special cases passed to the multiplier.
REQ-004 SHALL have parameter LAT, default 2, legal range >= 1, number of cycles the multiplier is held in BUSY.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset; synchronous and active-high.
REQ-007 req_valid  input  2  per-requester operation request; bit i is requester i.
REQ-008 req_ready  output  2  per-requester accept; a handshake occurs when req_valid[i] and req_ready[i] are both 1.
REQ-009 req_x0, req_y0  input  E+M+1 each  requester 0 HUB operands.
REQ-010 req_x1, req_y1  input  E+M+1 each  requester 1 HUB operands.
REQ-011 resp_valid  output  1  result available.
REQ-012 resp_ready  input  1  consumer accepts the result.
REQ-013 resp_id  output  1  requester that owns resp_z.
REQ-014 resp_z  output  E+M+1  HUB product.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 SHALL share one HUB multiplier instance between two requesters, with at most one operation outstanding.
REQ-017 FSM states SHALL be IDLE, BUSY and DONE; reset state is IDLE.
REQ-018 IDLE: if any req_valid bit is 1, SHALL assert exactly one req_ready bit (the grant), combinationally, in the same cycle.
- On that edge, SHALL capture the granted X/Y into operand registers and the grant index into resp_id.
- SHALL load cnt = LAT-1 and go to BUSY.
REQ-019 IDLE with req_valid = 00: SHALL assert no req_ready bit and stay in IDLE.
REQ-020 Arbitration SHALL be round-robin.
- With both requests valid, SHALL grant the requester not granted last.
- A single valid request SHALL be granted regardless of history.
- last_grant SHALL update only on a handshake.
REQ-021 req_ready SHALL be 00 in BUSY and DONE.
REQ-022 Multiplier start SHALL be 1 only in BUSY, with operands driven from the operand registers.
REQ-023 BUSY: SHALL decrement cnt each cycle.
- On the cycle cnt = 0, SHALL register the multiplier Z into resp_z and go to DONE.
REQ-024 DONE: SHALL hold resp_valid = 1, with resp_z and resp_id stable, until resp_ready = 1, then go to IDLE on that edge.
REQ-025 Latency: for a handshake in cycle t, resp_valid SHALL first be 1 in cycle t+LAT+1.
REQ-026 The earliest next grant SHALL be in the cycle after the response handshake, giving a peak throughput of one operation per LAT+2 cycles.
REQ-027 resp_z SHALL equal the multiplier result for the captured operands.
- This holds bit-exactly, including special-case results (±0, ±inf, ±1).
- Sign is X xor Y; exponent is Xe+Ye-2^(E-1), plus 1 on mantissa overflow.
REQ-028 A requester that deasserts req_valid before a grant SHALL lose nothing.
- Operands are sampled only on the handshake edge.
- Later changes to operand inputs SHALL NOT affect resp_z.
REQ-029 resp_ready asserted outside DONE SHALL be ignored.

Reset
REQ-030 rst = 1 SHALL, on the next clk edge, force the following values:
- state IDLE, cnt 0, last_grant 1 (so requester 0 wins the first tie);
- resp_valid 0, resp_id 0, resp_z 0, busy 0;
- operand registers 0.
REQ-031 rst asserted mid-operation (BUSY or DONE) SHALL abort the operation with no response ever issued.
- While rst = 1, req_ready SHALL be 00.

Structure
REQ-032 A shared package SHALL hold the FSM state enum (IDLE, BUSY, DONE) and the HUB bias constant 2^(E-1) as a function of E.
REQ-033 The single sub-module SHALL be FPHUB_mult, instantiated with M, E and special_case passed through.
- The multiplier instance SHALL NOT be duplicated.

Verification
REQ-034 Setup for all scenarios: E = 8, M = 23, LAT = 2.
REQ-035 Single request from requester 0 with req_x0 = req_y0 = 0x40800000 (non-special), resp_ready = 1 -> handshake at t; resp_valid at t+3 with resp_z = 0x41000001 and resp_id = 0; busy high over t+1..t+3.
REQ-036 Both requesters valid continuously with resp_ready = 1 -> grants alternate 0,1,0,1; handshakes 4 cycles apart.
REQ-037 resp_ready held 0 for 5 cycles in DONE -> resp_valid, resp_z and resp_id stable; req_ready stays 00; IDLE entered on the cycle after resp_ready = 1.
REQ-038 X sign 1, Y sign 0, same magnitudes as REQ-035 -> resp_z = 0xC1000001; an X of +0 -> resp_z equals the multiplier's special result.
REQ-039 rst pulsed during BUSY -> next cycle: all outputs 0, state IDLE, no resp_valid; a subsequent request completes normally with requester 0 winning a tie.
REQ-040 Operand inputs changed every cycle after the handshake -> resp_z reflects only the values present at the handshake.
